// File: rtl/bsg_circular_ptr_pair_ctrl.sv
// Ring-buffer read/write pointer pair with occupancy tracking and flow control.
// Optional almost_full_o output when BSG_CIRCULAR_PTR_PAIR_CTRL_ALMOST_FULL_EN is defined.
module bsg_circular_ptr_pair_ctrl #(
   parameter int slots_p   = 128,
   parameter int max_add_p = 10,
   localparam int ptr_w = $clog2(slots_p),
   localparam int n_w   = $clog2(max_add_p + 1),
   localparam int cnt_w = $clog2(slots_p + 1)
) (
   input  logic             clk,
   input  logic             reset_n_i,
`ifdef BSG_CIRCULAR_PTR_PAIR_CTRL_ALMOST_FULL_EN
   output logic             almost_full_o,
`endif
   input  logic             enq_v_i,
   input  logic [n_w-1:0]   enq_n_i,
   output logic             enq_ready_o,
   input  logic             deq_v_i,
   input  logic [n_w-1:0]   deq_n_i,
   output logic             deq_ready_o,
   output logic [ptr_w-1:0] wptr_o,
   output logic [ptr_w-1:0] wptr_n_o,
   output logic [ptr_w-1:0] rptr_o,
   output logic [ptr_w-1:0] rptr_n_o,
   output logic [cnt_w-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [ptr_w-1:0] wptr_r, rptr_r;
   logic [cnt_w-1:0] count_r, count_n;
   logic [cnt_w:0]   space, count_sum;
   logic [n_w-1:0]   ea, da;

   // Single conditional subtract is enough because an advance never exceeds slots_p.
   function automatic logic [ptr_w-1:0] wrap(input logic [ptr_w-1:0] p,
                                             input logic [n_w-1:0]   a);
      logic [ptr_w:0] s;
      s = {1'b0, p} + (ptr_w+1)'(a);
      if (s >= (ptr_w+1)'(slots_p))
         s = s - (ptr_w+1)'(slots_p);
      return ptr_w'(s);
   endfunction

   always_comb begin
      space       = (cnt_w+1)'(slots_p) - {1'b0, count_r};
      enq_ready_o = ((cnt_w+1)'(enq_n_i) <= space);
      deq_ready_o = ((cnt_w+1)'(deq_n_i) <= {1'b0, count_r});
      ea          = (enq_v_i & enq_ready_o) ? enq_n_i : '0;
      da          = (deq_v_i & deq_ready_o) ? deq_n_i : '0;
      wptr_n_o    = wrap(wptr_r, ea);
      rptr_n_o    = wrap(rptr_r, da);
      count_sum   = {1'b0, count_r} + (cnt_w+1)'(ea) - (cnt_w+1)'(da);
      count_n     = cnt_w'(count_sum);
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         wptr_r  <= wptr_n_o;
         rptr_r  <= rptr_n_o;
         count_r <= count_n;
      end
   end

`ifdef BSG_CIRCULAR_PTR_PAIR_CTRL_ALMOST_FULL_EN
   // Registered from next-cycle count so it lines up with count_o.
   localparam logic af_rst = (slots_p < max_add_p);
   logic [cnt_w:0] space_n;
   logic           almost_full_r;

   always_comb space_n = (cnt_w+1)'(slots_p) - {1'b0, count_n};

   always_ff @(posedge clk) begin
      if (!reset_n_i)
         almost_full_r <= af_rst;
      else
         almost_full_r <= (space_n < (cnt_w+1)'(max_add_p));
   end

   assign almost_full_o = almost_full_r;
`endif

   assign wptr_o  = wptr_r;
   assign rptr_o  = rptr_r;
   assign count_o = count_r;
   assign empty_o = (count_r == '0);
   assign full_o  = (count_r == cnt_w'(slots_p));

endmodule
